// File: rtl/comm_slave.sv
// UART receiver that assembles two consecutive 8N1 bytes (high byte first)
// into a 16-bit command with a level-style ready flag.
module comm_slave #(
    parameter int BAUD_CNT = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy
);

    localparam int CW = $clog2(BAUD_CNT + 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_CNT);
    localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_CNT / 2);

    typedef enum logic {IDLE, RECV} rx_state_t;
    typedef enum logic {HIGH, LOW} asm_state_t;

    rx_state_t  rx_state;
    asm_state_t asm_state;

    logic          rx_ff1, rx_ff2, rx_prev;
    logic          rx_fall;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift;
    logic          byte_rdy;
    logic [7:0]    high_byte;
    logic          unused_frame_bits;

    // Start and stop bits land in shift[0]/shift[9] and are never consumed.
    assign unused_frame_bits = shift[9] ^ shift[0];
    assign rx_fall = rx_prev & ~rx_ff2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1  <= 1'b1;
            rx_ff2  <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_ff1  <= RX;
            rx_ff2  <= rx_ff1;
            rx_prev <= rx_ff2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= 4'd0;
            shift    <= 10'd0;
            byte_rdy <= 1'b0;
        end else begin
            byte_rdy <= 1'b0;
            case (rx_state)
                IDLE: begin
                    if (rx_fall) begin
                        baud_cnt <= HALF_BIT;
                        bit_cnt  <= 4'd0;
                        rx_state <= RECV;
                    end
                end
                RECV: begin
                    // A count of 1 here means the decrement reaches zero this edge.
                    if (baud_cnt == CW'(1)) begin
                        shift    <= {rx_ff2, shift[9:1]};
                        baud_cnt <= FULL_BIT;
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd0 && rx_ff2) begin
                            rx_state <= IDLE;
                        end else if (bit_cnt == 4'd9) begin
                            rx_state <= IDLE;
                            byte_rdy <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    // Set beats clear: the LOW-byte branch ignores clr_cmd_rdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_state <= HIGH;
            high_byte <= 8'h00;
            cmd       <= 16'h0000;
            cmd_rdy   <= 1'b0;
        end else if (byte_rdy) begin
            if (asm_state == HIGH) begin
                high_byte <= shift[8:1];
                cmd_rdy   <= 1'b0;
                asm_state <= LOW;
            end else begin
                cmd       <= {high_byte, shift[8:1]};
                cmd_rdy   <= 1'b1;
                asm_state <= HIGH;
            end
        end else if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_comm_slave.sv
// Directed bench for comm_slave: a fast instance (16 clk/bit) for most steps
// and a default-rate instance driven by a bench-side transmitter.
module tb_comm_slave;

    localparam int FB = 16;
    localparam int DB = 2604;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx, clr;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        rx_def, clr_def;
    logic [15:0] cmd_def;
    logic        cmd_rdy_def;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    comm_slave #(.BAUD_CNT(FB)) u_dut (
        .clk(clk), .rst_n(rst_n), .RX(rx), .clr_cmd_rdy(clr),
        .cmd(cmd), .cmd_rdy(cmd_rdy)
    );

    comm_slave u_dut_def (
        .clk(clk), .rst_n(rst_n), .RX(rx_def), .clr_cmd_rdy(clr_def),
        .cmd(cmd_def), .cmd_rdy(cmd_rdy_def)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start + 8 data bits LSB first, then a stop bit held stop_len clocks.
    // Called and returns on a falling clock edge.
    task automatic send_bits(input logic [7:0] b, input int stop_len);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int i = 0; i < 9; i++) begin
            rx = bits[i];
            repeat (FB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (stop_len) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(b, FB);
    endtask

    task automatic send_def(input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_def = bits[i];
            repeat (DB) @(negedge clk);
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rx = 1'b1; clr = 1'b0; rx_def = 1'b1; clr_def = 1'b0;

        // 1: reset with RX toggling, then idle line
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = (i % 2 == 0) ? 1'b0 : 1'b1;
        end
        check("t1_rst_cmd", cmd, 16'h0000);
        check("t1_rst_rdy", {15'd0, cmd_rdy}, 16'd0);
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("t1_idle_rdy", {15'd0, cmd_rdy}, 16'd0);
        check("t1_idle_cmd", cmd, 16'h0000);

        // 2: basic command, exact latency, then clear
        send_frame(8'hA5);
        send_bits(8'h3C, 11);
        check("t2_rdy_not_early", {15'd0, cmd_rdy}, 16'd0);
        @(negedge clk);
        check("t2_rdy", {15'd0, cmd_rdy}, 16'd1);
        check("t2_cmd", cmd, 16'hA53C);
        repeat (4) @(negedge clk);
        pulse_clr();
        check("t2_clr_rdy", {15'd0, cmd_rdy}, 16'd0);
        check("t2_clr_cmd", cmd, 16'hA53C);

        // 3: four contiguous frames, no clear
        send_frame(8'h12);
        send_bits(8'h34, 11);
        @(negedge clk);
        check("t3_rdy1", {15'd0, cmd_rdy}, 16'd1);
        check("t3_cmd1", cmd, 16'h1234);
        repeat (4) @(negedge clk);
        send_bits(8'hFF, 11);
        check("t3_rdy_before_ff", {15'd0, cmd_rdy}, 16'd1);
        @(negedge clk);
        check("t3_rdy_fall", {15'd0, cmd_rdy}, 16'd0);
        check("t3_cmd_hold", cmd, 16'h1234);
        repeat (4) @(negedge clk);
        send_bits(8'h00, 11);
        @(negedge clk);
        check("t3_rdy2", {15'd0, cmd_rdy}, 16'd1);
        check("t3_cmd2", cmd, 16'hFF00);
        repeat (4) @(negedge clk);

        // 4: short low glitch must not start a byte
        pulse_clr();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("t4_glitch_rdy", {15'd0, cmd_rdy}, 16'd0);
        send_frame(8'hBE);
        check("t4_first_rdy", {15'd0, cmd_rdy}, 16'd0);
        send_frame(8'hEF);
        check("t4_rdy", {15'd0, cmd_rdy}, 16'd1);
        check("t4_cmd", cmd, 16'hBEEF);

        // 5: reset during the second frame's data bits (line high at that point)
        repeat (20) @(negedge clk);
        send_frame(8'h55);
        fork
            send_frame(8'hF0);
            begin
                repeat (100) @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        check("t5_rst_cmd", cmd, 16'h0000);
        check("t5_rst_rdy", {15'd0, cmd_rdy}, 16'd0);
        repeat (50) @(negedge clk);
        send_frame(8'hC3);
        send_frame(8'h0F);
        check("t5_rdy", {15'd0, cmd_rdy}, 16'd1);
        check("t5_cmd", cmd, 16'hC30F);

        // set and clear in the same cycle: set wins
        pulse_clr();
        send_frame(8'h7E);
        send_bits(8'h81, 11);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t6_setclr_rdy", {15'd0, cmd_rdy}, 16'd1);
        check("t6_setclr_cmd", cmd, 16'h7E81);
        repeat (4) @(negedge clk);

        // 6: loopback at the default bit rate
        send_def(8'h80);
        check("t6_def_half_rdy", {15'd0, cmd_rdy_def}, 16'd0);
        send_def(8'h01);
        check("t6_def_rdy", {15'd0, cmd_rdy_def}, 16'd1);
        check("t6_def_cmd", cmd_def, 16'h8001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
